// File: rtl/vga_capture.sv
// VGA stream receiver: rebuilds pixel coordinates from hsync/vsync/valid and writes each active pixel to a row-major frame store.
// Optional running pixel checksum enabled by defining VGA_CAP_CHECKSUM_EN.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              err,
  output logic [23:0]       checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic              hsync_reg, vsync_reg, valid_reg;
  logic              hsync_prev, vsync_prev, valid_prev;
  logic [23:0]       rgb_reg;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] lin_addr;
  logic              vs_fall, hs_fall, valid_rise, valid_fall;
  logic              frame_start, take, in_range, line_end, last_line;

  assign vs_fall     = vsync_prev & ~vsync_reg;
  assign hs_fall     = hsync_prev & ~hsync_reg;
  assign valid_rise  = valid_reg & ~valid_prev;
  assign valid_fall  = valid_prev & ~valid_reg;
  assign frame_start = (state == S_IDLE) && vs_fall && cap_en;
  // A pixel is consumed on the line-opening rising edge and on every valid cycle inside the line.
  assign take        = !vs_fall && (((state == S_WAIT) && valid_rise) ||
                                    ((state == S_ACTIVE) && valid_reg));
  assign line_end    = (state == S_ACTIVE) && !vs_fall && !valid_reg && valid_fall;
  assign in_range    = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
  assign last_line   = (32'(y) + 32'd1) == V_ACTIVE;

  generate
    if (H_ACTIVE == 640) begin : g_addr_shift
      assign lin_addr = ADDR_W'({y, 9'd0}) + ADDR_W'({y, 7'd0}) + ADDR_W'(x);
    end else begin : g_addr_mul
      assign lin_addr = ADDR_W'(32'(y) * H_ACTIVE + 32'(x));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      valid_reg  <= 1'b0;
      hsync_prev <= 1'b1;
      vsync_prev <= 1'b1;
      valid_prev <= 1'b0;
      rgb_reg    <= '0;
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      hsync_reg  <= hsync;
      vsync_reg  <= vsync;
      valid_reg  <= valid;
      rgb_reg    <= {vga_r, vga_g, vga_b};
      hsync_prev <= hsync_reg;
      vsync_prev <= vsync_reg;
      valid_prev <= valid_reg;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state <= S_WAIT;
            x     <= '0;
            y     <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_WAIT, S_ACTIVE: begin
          // A vsync edge mid-frame aborts; it does not double as the next frame start.
          if (vs_fall) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (hs_fall && valid_reg) err <= 1'b1;
            if (state == S_WAIT && valid_rise) state <= S_ACTIVE;
            if (line_end) begin
              if (32'(x) != H_ACTIVE) err <= 1'b1;
              x     <= '0;
              y     <= y + 9'd1;
              state <= last_line ? S_DONE : S_WAIT;
            end
          end
        end
        default: begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase

      if (take) begin
        if (in_range) begin
          wr_en   <= 1'b1;
          wr_addr <= lin_addr;
          wr_data <= rgb_reg;
        end else begin
          err <= 1'b1;
        end
        x <= x + 10'd1;
      end
    end
  end

`ifdef VGA_CAP_CHECKSUM_EN
  logic [23:0] sum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_reg  <= '0;
      checksum <= '0;
    end else begin
      if (frame_start) sum_reg <= '0;
      else if (take && in_range) sum_reg <= sum_reg + rgb_reg;
      if (state == S_DONE) checksum <= sum_reg;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
